shared_mem_arbiter: RTL and testbench
=====================================

Name: shared_mem_arbiter

Overview:
- Arbitrates one single-port synchronous data RAM among NUM_REQ requesters.
- Requesters are the systolic controller (matrix A/B fetch, C writeback), the host loader and the debug/readback port.
- Round-robin fairness, with an optional lock for bursts. Bursts are capped at MAX_BURST accesses so a long matrix fetch cannot starve the host.
- Sits between the requesters and the RAM. It exposes a per-requester request/grant handshake and a 1-cycle read-return path.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = highest tie-break precedence after reset).
- ADDR_W, 12, RAM address width.
- DATA_W, 16, RAM data width.
- MAX_BURST, 32, maximum consecutive locked accesses per grant; 0 = unlimited.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester access request; held until the access is taken.
- lock  in  NUM_REQ  keep the grant after the current access.
- we  in  NUM_REQ  1 = write, 0 = read, per requester.
- addr  in  NUM_REQ x ADDR_W  per-requester address.
- wdata  in  NUM_REQ x DATA_W  per-requester write data.
- gnt  out  NUM_REQ  registered one-hot grant.
- rvalid  out  NUM_REQ  read data valid for that requester.
- rdata  out  DATA_W  read data, broadcast to all requesters (qualify with rvalid).
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read.
- clr_stats  in  1  synchronous clear of busy_cycles.
- busy_cycles  out  16  count of cycles with mem_en=1, saturating at 0xFFFF.

Behaviour:
- Reset values:
  - all outputs 0; gnt=0, rvalid=0, rdata=0, busy_cycles=0;
  - state=ARB, rr_ptr=0, owner=0, burst_cnt=0.
  - Reset mid-access drops any pending rvalid; the RAM sees mem_en=0 from reset onward.
- State ARB:
  - gnt=0, mem_en=0.
  - If req != 0, the winner is the first i with req[i]=1, searching cyclically from rr_ptr.
  - On the winner: owner<=winner, gnt[winner]<=1, burst_cnt<=0, state<=OWN.
  - If req == 0, stay in ARB.
- State OWN, with req[owner]=1:
  - mem_en=1, mem_we=we[owner], mem_addr=addr[owner], mem_wdata=wdata[owner] (combinational mux on the registered owner).
  - The access completes in this cycle; burst_cnt<=burst_cnt+1.
- State OWN, release rule:
  - Release after the access when any of these holds: lock[owner]=0; or MAX_BURST!=0 and burst_cnt+1==MAX_BURST.
  - Also release when req[owner]=0 (no access issued).
  - Release action: gnt<=0, rr_ptr<=(owner+1) mod NUM_REQ, state<=ARB.
  - There is no same-cycle handoff: at least one ARB cycle separates grants.
- State OWN, defaults:
  - Non-owners are ignored.
  - mem_* outputs are 0 whenever mem_en=0.
- Throughput:
  - unlocked single access: 1 access per 2 cycles;
  - locked burst: 1 access per cycle up to MAX_BURST.
- Read return:
  - For a read issued in cycle t, rvalid[owner]=1 and rdata=mem_rdata in cycle t+1, registered.
  - The return is still delivered if the grant was released at t.
  - rvalid is a single-cycle pulse per read.
  - Writes produce no rvalid.
- Requester contract:
  - req, we, addr, wdata stay stable until the cycle the requester sees gnt=1 with its req=1 (access taken).
  - Deasserting req before grant withdraws the request; this is legal.
- busy_cycles:
  - increments on each cycle with mem_en=1;
  - saturates at 0xFFFF;
  - clr_stats forces 0 and takes priority over the increment in the same cycle.
- Invariants:
  - gnt is one-hot or zero;
  - mem_en implies gnt[owner]=1 and req[owner]=1;
  - rr_ptr < NUM_REQ.

Test Plan:
- Single read:
  - Stimulus: req[0]=1, we=0, addr=0x010, lock=0; RAM holds 0x1234.
  - Response: gnt[0]=1 at cycle 1; mem_en=1 with mem_addr=0x010 at cycle 1; rvalid[0]=1 with rdata=0x1234 at cycle 2; gnt=0 at cycle 2; busy_cycles=1.
- Round-robin:
  - Stimulus: req=3'b111 held, lock=0.
  - Response: grant order 0,1,2,0,1,2; each grant 1 cycle with an ARB cycle between; no requester gets two grants in a row.
- Locked burst:
  - Stimulus: requester 1 locked, 16 sequential reads 0x100..0x10F; requester 2 requesting throughout.
  - Response: 16 back-to-back mem_en cycles; rvalid[1] 16 consecutive cycles; gnt[2] follows after release; rr_ptr=2.
- Burst cap:
  - Stimulus: MAX_BURST=4; requester 0 with lock=1, req=1 continuous; requester 1 requesting.
  - Response: exactly 4 accesses, then forced release; gnt[1] 2 cycles after the 4th access.
- Writes and clears:
  - Stimulus: write of 0xBEEF to 0x020 by requester 2, then a read of 0x020 by requester 0.
  - Response: mem_we=1 with mem_wdata=0xBEEF; no rvalid for the write; rdata=0xBEEF on rvalid[0].
  - Stimulus: clr_stats and mem_en in the same cycle → Response: busy_cycles=0.
- Reset mid-burst:
  - Stimulus: assert rst during a locked read burst.
  - Response: gnt, rvalid, mem_en go to 0 immediately; after release, first grant goes to lowest requesting index (rr_ptr=0).

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NUM_REQ requesters,
// with optional locked bursts capped at MAX_BURST accesses and a busy-cycle counter.
module shared_mem_arbiter #(
   parameter int unsigned NUM_REQ   = 3,
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MAX_BURST = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          i_req,
   input  logic [NUM_REQ-1:0]          i_lock,
   input  logic [NUM_REQ-1:0]          i_we,
   input  logic [NUM_REQ*ADDR_W-1:0]   i_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   i_wdata,
   output logic [NUM_REQ-1:0]          o_gnt,
   output logic [NUM_REQ-1:0]          o_rvalid,
   output logic [DATA_W-1:0]           o_rdata,
   output logic                        o_mem_en,
   output logic                        o_mem_we,
   output logic [ADDR_W-1:0]           o_mem_addr,
   output logic [DATA_W-1:0]           o_mem_wdata,
   input  logic [DATA_W-1:0]           i_mem_rdata,
   input  logic                        i_clr_stats,
   output logic [15:0]                 o_busy_cycles
);

   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BW-1:0] LastBeat = BW'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);

   typedef enum logic {StArb, StOwn} state_t;

   state_t               r_state;
   logic [PW-1:0]        r_owner;
   logic [PW-1:0]        r_rr_ptr;
   logic [BW-1:0]        r_burst_cnt;
   logic [NUM_REQ-1:0]   r_gnt;
   logic [NUM_REQ-1:0]   r_rvalid;
   logic [15:0]          r_busy;

   logic                 w_found;
   logic [PW-1:0]        w_winner;
   logic                 w_mem_en;
   logic                 w_own_we;
   logic                 w_cap;
   logic                 w_release;
   logic [PW-1:0]        w_next_ptr;

   // Cyclic first-set search starting at the round-robin pointer.
   always_comb begin : p_search
      int unsigned idx;
      w_found  = 1'b0;
      w_winner = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!w_found && i_req[idx]) begin
            w_found  = 1'b1;
            w_winner = PW'(idx);
         end
      end
   end

   always_comb begin
      w_mem_en   = (r_state == StOwn) && i_req[r_owner];
      w_own_we   = i_we[r_owner];
      w_cap      = (MAX_BURST != 0) && (r_burst_cnt == LastBeat);
      w_release  = !i_req[r_owner] || !i_lock[r_owner] || w_cap;
      w_next_ptr = (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StArb;
         r_owner     <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
         r_gnt       <= '0;
         r_rvalid    <= '0;
         r_busy      <= '0;
      end else begin
         r_rvalid <= '0;
         if (w_mem_en && !w_own_we) r_rvalid[r_owner] <= 1'b1;

         if (i_clr_stats)                          r_busy <= '0;
         else if (w_mem_en && r_busy != 16'hFFFF)  r_busy <= r_busy + 16'd1;

         case (r_state)
            StArb: begin
               if (w_found) begin
                  r_owner     <= w_winner;
                  r_gnt       <= NUM_REQ'(1) << w_winner;
                  r_burst_cnt <= '0;
                  r_state     <= StOwn;
               end
            end
            StOwn: begin
               if (w_release) begin
                  r_gnt    <= '0;
                  r_rr_ptr <= w_next_ptr;
                  r_state  <= StArb;
               end else begin
                  r_burst_cnt <= r_burst_cnt + 1'b1;
               end
            end
            default: r_state <= StArb;
         endcase
      end
   end

   // RAM read data arrives the cycle after the read, aligned with r_rvalid.
   assign o_rdata       = (|r_rvalid) ? i_mem_rdata : '0;
   assign o_gnt         = r_gnt;
   assign o_rvalid      = r_rvalid;
   assign o_busy_cycles = r_busy;
   assign o_mem_en      = w_mem_en;
   assign o_mem_we      = w_mem_en & w_own_we;
   assign o_mem_addr    = w_mem_en ? i_addr[int'(r_owner)*ADDR_W +: ADDR_W] : '0;
   assign o_mem_wdata   = w_mem_en ? i_wdata[int'(r_owner)*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: directed scenarios plus random traffic, all cycles checked
// against a transaction-level reference model with its own memory image.
module tb_shared_mem_arbiter;

   localparam int N  = 3;
   localparam int MB = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req, lock, we;
   logic [11:0]   addr_a [N];
   logic [15:0]   wdata_a [N];
   logic          clr;
   logic [N-1:0]  gnt, rvalid;
   logic [15:0]   rdata, mem_wdata, mem_rdata;
   logic          mem_en, mem_we;
   logic [11:0]   mem_addr;
   logic [15:0]   busy;
   logic [N*12-1:0] addr_f;
   logic [N*16-1:0] wdata_f;

   assign addr_f  = {addr_a[2], addr_a[1], addr_a[0]};
   assign wdata_f = {wdata_a[2], wdata_a[1], wdata_a[0]};

   always #5 clk = ~clk;

   shared_mem_arbiter #(.NUM_REQ(N), .ADDR_W(12), .DATA_W(16), .MAX_BURST(MB)) u_dut (
      .clk(clk), .rst(rst), .i_req(req), .i_lock(lock), .i_we(we), .i_addr(addr_f),
      .i_wdata(wdata_f), .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata), .o_mem_en(mem_en),
      .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata), .i_clr_stats(clr), .o_busy_cycles(busy)
   );

   function automatic logic [15:0] init_val(input logic [11:0] a);
      return {a[3:0], a} ^ 16'h5A3C;
   endfunction

   // Synchronous single-port RAM seen by the DUT.
   logic [15:0] ram [4096];
   bit          ram_w [4096];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr]   <= mem_wdata;
            ram_w[mem_addr] <= 1'b1;
         end else begin
            mem_rdata <= ram_w[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference model: who holds the RAM, how many beats it has used, pending read return.
   logic [15:0] ref_mem [4096];
   bit          ref_w [4096];
   int          m_owner, m_ptr, m_beats, m_rv, m_busy, m_taken;
   logic [15:0] m_rd;

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_beats = 0; m_rv = -1; m_rd = '0; m_busy = 0; m_taken = -1;
   endtask

   task automatic check_cycle();
      logic [N-1:0] eg, erv;
      logic         een;
      eg = '0; erv = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      if (m_rv >= 0) erv[m_rv] = 1'b1;
      een = (m_owner >= 0) && req[m_owner];
      check_val("gnt", gnt, eg);
      check_val("mem_en", mem_en, een);
      check_val("mem_we", mem_we, een ? we[m_owner] : 1'b0);
      check_val("mem_addr", mem_addr, een ? addr_a[m_owner] : 12'h0);
      check_val("mem_wdata", mem_wdata, een ? wdata_a[m_owner] : 16'h0);
      check_val("rvalid", rvalid, erv);
      check_val("rdata", rdata, (m_rv >= 0) ? m_rd : 16'h0);
      check_val("busy", busy, m_busy);
   endtask

   task automatic model_step();
      int   o;
      logic acc;
      o = m_owner;
      acc = (o >= 0) && req[o];
      m_taken = acc ? o : -1;
      m_rv = -1;
      if (acc) begin
         if (we[o]) begin
            ref_mem[addr_a[o]] = wdata_a[o];
            ref_w[addr_a[o]]   = 1'b1;
         end else begin
            m_rv = o;
            m_rd = ref_w[addr_a[o]] ? ref_mem[addr_a[o]] : init_val(addr_a[o]);
         end
      end
      if (clr)      m_busy = 0;
      else if (acc) m_busy = (m_busy == 65535) ? 65535 : m_busy + 1;
      if (o < 0) begin
         for (int k = 0; k < N; k++)
            if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
         m_beats = 0;
      end else begin
         if (acc) m_beats++;
         if (!acc || !lock[o] || (MB != 0 && m_beats == MB)) begin
            m_owner = -1;
            m_ptr   = (o + 1) % N;
         end
      end
   endtask

   task automatic step();
      #1;
      check_cycle();
      model_step();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      req = '0; lock = '0; we = '0; clr = 1'b0;
      for (int i = 0; i < N; i++) begin
         addr_a[i] = '0; wdata_a[i] = '0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      #1;
      check_val("rst_gnt", gnt, 3'b000);
      check_val("rst_mem_en", mem_en, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Issue one unlocked access; returns the number of cycles up to and including the access.
   task automatic issue(input int i, input logic w, input logic [11:0] a, input logic [15:0] d,
                        output int ncyc);
      req[i] = 1'b1; we[i] = w; addr_a[i] = a; wdata_a[i] = d; lock[i] = 1'b0;
      ncyc = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         ncyc++;
         if (m_taken == i) break;
      end
      if (m_taken != i) check_val("issue_timeout", 0, 1);
      req[i] = 1'b0;
   endtask

   initial begin
      int n, cyc, en1, rv1, first1, last1, g2, cnt0, last0, g1;
      logic [N-1:0] gq [$];
      rst = 1'b1;
      clear_inputs();
      model_reset();
      @(negedge clk);
      #1;
      check_val("reset_rvalid", rvalid, 3'b000);
      check_val("reset_rdata", rdata, 16'h0);
      check_val("reset_busy", busy, 16'h0);
      check_val("reset_gnt", gnt, 3'b000);
      @(negedge clk);
      rst = 1'b0;

      // Writes, then reads back; clr first so busy counts only the read.
      issue(1, 1'b1, 12'h010, 16'h1234, n);
      issue(2, 1'b1, 12'h020, 16'hBEEF, n);
      #1;
      check_val("write_no_rvalid", rvalid, 3'b000);
      clr = 1'b1;
      step();
      clr = 1'b0;
      issue(0, 1'b0, 12'h010, 16'h0, n);
      check_val("single_rd_latency", n, 2);
      #1;
      check_val("single_rvalid", rvalid, 3'b001);
      check_val("single_rdata", rdata, 16'h1234);
      check_val("single_gnt_drop", gnt, 3'b000);
      check_val("single_busy", busy, 16'd1);
      step();
      issue(0, 1'b0, 12'h020, 16'h0, n);
      #1;
      check_val("wr_rd_rdata", rdata, 16'hBEEF);
      step();

      // clr_stats wins over an access in the same cycle.
      clr = 1'b1;
      issue(0, 1'b0, 12'h005, 16'h0, n);
      #1;
      check_val("clr_priority_busy", busy, 16'h0);
      clr = 1'b0;
      step();

      // Round robin with all requesters held.
      do_reset();
      req = 3'b111;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (gnt != 0) gq.push_back(gnt);
         step();
      end
      req = '0;
      check_val("rr_count", gq.size(), 6);
      for (int k = 0; k < 6 && k < gq.size(); k++) check_val("rr_order", gq[k], 3'b001 << (k % 3));
      step();

      // Locked 16-beat read burst by requester 1 while requester 2 waits.
      do_reset();
      req[2] = 1'b1; addr_a[2] = 12'h300;
      req[1] = 1'b1; lock[1] = 1'b1; addr_a[1] = 12'h100;
      en1 = 0; rv1 = 0; first1 = -1; last1 = -1; g2 = -1; n = 0;
      for (cyc = 0; cyc < 60; cyc++) begin
         #1;
         if (mem_en && gnt[1]) begin
            en1++;
            if (first1 < 0) first1 = cyc;
            last1 = cyc;
         end
         if (rvalid[1]) rv1++;
         if (gnt[2] && g2 < 0) g2 = cyc;
         step();
         if (m_taken == 1) begin
            n++;
            addr_a[1] = addr_a[1] + 12'd1;
            if (n == 15) lock[1] = 1'b0;
            if (n == 16) req[1] = 1'b0;
         end
         if (m_taken == 2) break;
      end
      req = '0; lock = '0;
      check_val("burst_en_count", en1, 16);
      check_val("burst_contiguous", last1 - first1, 15);
      check_val("burst_rvalid_count", rv1, 16);
      check_val("burst_next_gnt", g2 - last1, 2);
      step();

      // Lock held forever by requester 0: cap forces release after MB beats.
      do_reset();
      req[0] = 1'b1; lock[0] = 1'b1; addr_a[0] = 12'h040;
      req[1] = 1'b1; addr_a[1] = 12'h041;
      cnt0 = 0; last0 = -1; g1 = -1;
      for (cyc = 0; cyc < 3 * MB; cyc++) begin
         #1;
         if (mem_en && gnt[0] && g1 < 0) begin
            cnt0++;
            last0 = cyc;
         end
         if (gnt[1] && g1 < 0) g1 = cyc;
         step();
         if (m_taken == 1) break;
      end
      req = '0; lock = '0;
      check_val("cap_beats", cnt0, MB);
      check_val("cap_gap", g1 - last0, 2);
      step();

      // Reset mid locked burst; pointer must return to 0 afterwards.
      req[1] = 1'b1; lock[1] = 1'b1; addr_a[1] = 12'h200;
      for (int c = 0; c < 6; c++) step();
      #2;
      rst = 1'b1;
      #1;
      check_val("midrst_gnt", gnt, 3'b000);
      check_val("midrst_rvalid", rvalid, 3'b000);
      check_val("midrst_mem_en", mem_en, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      clear_inputs();
      req = 3'b101;
      step();
      #1;
      check_val("postrst_first_gnt", gnt, 3'b001);
      req = '0;
      step();
      step();

      // Random traffic obeying the requester contract.
      for (int c = 0; c < 3000; c++) begin
         step();
         clr = ($urandom_range(63) == 0);
         for (int i = 0; i < N; i++) begin
            if (m_taken == i || !req[i]) begin
               req[i]     = ($urandom_range(2) != 0);
               we[i]      = $urandom_range(1);
               lock[i]    = ($urandom_range(3) != 0);
               addr_a[i]  = 12'($urandom_range(63));
               wdata_a[i] = 16'($urandom);
            end else if (m_owner != i && $urandom_range(15) == 0) begin
               req[i] = 1'b0;
            end
         end
      end
      clear_inputs();
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
